// File: rtl/paint_cursor_ctrl_if.sv
// paint_cursor_ctrl_if
//   Bundles the link between the cursor controller, the square drawer and the
//   VGA write port.
//   sq_start        controller -> drawer : run request, held for the whole run
//   sq_x, sq_y      controller -> drawer : square origin
//   sq_sx, sq_sy    controller -> drawer : square size (side = size+1)
//   sq_done         drawer -> controller : run complete, sticky until next start
//   plot            controller -> VGA    : pixel write enable
//   colour_out      controller -> VGA    : pixel colour
interface paint_cursor_ctrl_if;
  logic       sq_start;
  logic [7:0] sq_x;
  logic [7:0] sq_y;
  logic [3:0] sq_sx;
  logic [3:0] sq_sy;
  logic       sq_done;
  logic       plot;
  logic [2:0] colour_out;

  modport master (
    output sq_start, sq_x, sq_y, sq_sx, sq_sy, plot, colour_out,
    input  sq_done
  );

  modport slave (
    input  sq_start, sq_x, sq_y, sq_sx, sq_sy, plot, colour_out,
    output sq_done
  );
endinterface

// File: rtl/paint_cursor_ctrl.sv
// paint_cursor_ctrl
//   Holds the brush cursor and turns move/refresh requests into square-drawer
//   runs. With paint=0 the old square is erased in BG_COLOUR before the cursor
//   moves; with paint=1 the erase is skipped and a trail is left.
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   move_up/down/left/right, refresh
//                        one-cycle requests, accumulated until consumed
//   paint                level, 1 = leave trail
//   colour_in, size_in   brush colour and size (side = size_in+1)
//   sq                   drawer/VGA link (master side)
//   cur_x, cur_y         current cursor origin
//   busy                 high whenever the controller is not idle
module paint_cursor_ctrl #(
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter int unsigned STEP      = 1,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       move_up,
  input  logic                       move_down,
  input  logic                       move_left,
  input  logic                       move_right,
  input  logic                       refresh,
  input  logic                       paint,
  input  logic [2:0]                 colour_in,
  input  logic [3:0]                 size_in,
  paint_cursor_ctrl_if.master        sq,
  output logic [7:0]                 cur_x,
  output logic [7:0]                 cur_y,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ERASE,
    S_MOVE,
    S_DRAW
  } state_e;

  localparam logic [8:0] STEP9  = 9'(STEP);
  localparam logic [8:0] X_MAX9 = 9'(SCREEN_W - 1);
  localparam logic [8:0] Y_MAX9 = 9'(SCREEN_H - 1);

  // Request mask bit positions: {refresh, R, L, D, U}
  localparam int unsigned B_U = 0;
  localparam int unsigned B_D = 1;
  localparam int unsigned B_L = 2;
  localparam int unsigned B_R = 3;

  state_e     state_q, state_d;
  logic [7:0] cur_x_q, cur_x_d;
  logic [7:0] cur_y_q, cur_y_d;
  logic [4:0] pending_q, pending_d;
  logic [3:0] drawn_size_q, drawn_size_d;
  logic [2:0] drawn_colour_q, drawn_colour_d;
  logic       sq_start_q;

  logic [4:0] req;
  logic       start_c;
  logic [2:0] colour_c;
  logic       done_ack;
  logic [8:0] x9, y9;
  logic [8:0] x_lim, y_lim;

  assign req = {refresh, move_right, move_left, move_down, move_up};

  // Drawer's Done is sticky from the previous run; on the first cycle of a run
  // sq_start_q is still low, which masks the stale value.
  assign done_ack = start_c & sq_start_q & sq.sq_done;

  // New position from the pending mask. Opposite requests cancel, decrements
  // saturate at 0, and the result is clamped so the square (with the size
  // about to be latched) stays on screen.
  always_comb begin
    x_lim = X_MAX9 - {5'b0, size_in};
    y_lim = Y_MAX9 - {5'b0, size_in};
    x9    = {1'b0, cur_x_q};
    y9    = {1'b0, cur_y_q};
    if (pending_q[B_R] && !pending_q[B_L]) begin
      x9 = x9 + STEP9;
    end else if (pending_q[B_L] && !pending_q[B_R]) begin
      x9 = (x9 < STEP9) ? '0 : x9 - STEP9;
    end
    if (pending_q[B_D] && !pending_q[B_U]) begin
      y9 = y9 + STEP9;
    end else if (pending_q[B_U] && !pending_q[B_D]) begin
      y9 = (y9 < STEP9) ? '0 : y9 - STEP9;
    end
    if (x9 > x_lim) x9 = x_lim;
    if (y9 > y_lim) y9 = y_lim;
  end

  always_comb begin
    state_d        = state_q;
    cur_x_d        = cur_x_q;
    cur_y_d        = cur_y_q;
    pending_d      = pending_q | req;
    drawn_size_d   = drawn_size_q;
    drawn_colour_d = drawn_colour_q;
    start_c        = 1'b0;
    colour_c       = drawn_colour_q;

    unique case (state_q)
      S_INIT: begin
        drawn_size_d   = size_in;
        drawn_colour_d = colour_in;
        state_d        = S_DRAW;
      end
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = paint ? S_MOVE : S_ERASE;
        end
      end
      S_ERASE: begin
        start_c  = 1'b1;
        colour_c = BG_COLOUR;
        if (start_c && sq_start_q && sq.sq_done) begin
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        // Everything pending is consumed here; only same-cycle requests survive.
        pending_d      = req;
        cur_x_d        = x9[7:0];
        cur_y_d        = y9[7:0];
        drawn_size_d   = size_in;
        drawn_colour_d = colour_in;
        state_d        = S_DRAW;
      end
      S_DRAW: begin
        start_c = 1'b1;
        if (start_c && sq_start_q && sq.sq_done) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_INIT;
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      pending_q      <= '0;
      drawn_size_q   <= '0;
      drawn_colour_q <= '0;
      sq_start_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_x_q        <= cur_x_d;
      cur_y_q        <= cur_y_d;
      pending_q      <= pending_d;
      drawn_size_q   <= drawn_size_d;
      drawn_colour_q <= drawn_colour_d;
      sq_start_q     <= start_c;
    end
  end

  // sq_start is decoded from the state register, so an async reset drops it
  // (and plot) in the same instant.
  assign sq.sq_start   = start_c;
  assign sq.sq_x       = cur_x_q;
  assign sq.sq_y       = cur_y_q;
  assign sq.sq_sx      = drawn_size_q;
  assign sq.sq_sy      = drawn_size_q;
  assign sq.plot       = start_c & sq_start_q & ~sq.sq_done;
  assign sq.colour_out = colour_c;

  assign cur_x = cur_x_q;
  assign cur_y = cur_y_q;
  assign busy  = (state_q != S_IDLE);

  logic unused_ack;
  assign unused_ack = done_ack;

endmodule

// File: tb/tb_paint_cursor_ctrl.sv
// Bench for paint_cursor_ctrl: a square-drawer stand-in, a cycle-level
// reference model driven by run-cycle counting, directed scenarios with
// literal expectations, then randomized requests and resets.
module tb_paint_cursor_ctrl;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int ST = 1;
  localparam int BG = 0;

  localparam int M_INIT  = 0;
  localparam int M_IDLE  = 1;
  localparam int M_ERASE = 2;
  localparam int M_MOVE  = 3;
  localparam int M_DRAW  = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       mu = 0, md = 0, ml = 0, mr = 0, rf = 0, paint = 0;
  logic [2:0] colour_in = 3'b100;
  logic [3:0] size_in = 4'd1;
  logic [7:0] cur_x, cur_y;
  logic       busy;

  int checks = 0;
  int errors = 0;

  paint_cursor_ctrl_if sq ();

  paint_cursor_ctrl #(
    .SCREEN_W (W),
    .SCREEN_H (H),
    .STEP     (ST),
    .BG_COLOUR(3'b000)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .move_up   (mu),
    .move_down (md),
    .move_left (ml),
    .move_right(mr),
    .refresh   (rf),
    .paint     (paint),
    .colour_in (colour_in),
    .size_in   (size_in),
    .sq        (sq),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Square drawer stand-in: no reset, sticky Done, first start cycle reloads,
  // then walks offsets x outer / y inner, both counting down.
  logic       d_active = 1'b0;
  logic       d_done = 1'b1;
  logic [3:0] d_xo = '0, d_yo = '0;
  assign sq.sq_done = d_done;

  always @(posedge clk) begin
    if (!sq.sq_start) begin
      d_active <= 1'b0;
    end else if (!d_active) begin
      d_active <= 1'b1;
      d_done   <= 1'b0;
      d_xo     <= sq.sq_sx;
      d_yo     <= sq.sq_sy;
    end else if (!d_done) begin
      if (d_yo != 0) d_yo <= d_yo - 4'd1;
      else if (d_xo != 0) begin
        d_xo <= d_xo - 4'd1;
        d_yo <= sq.sq_sy;
      end else d_done <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase, cursor, pending mask, and a counter of cycles
  // into the current run. A run lasts (s+1)^2 + 2 cycles.
  int       m_mode = M_INIT;
  int       m_cx = 0, m_cy = 0, m_ds = 0, m_dc = 0, m_rc = 0;
  bit [4:0] m_pend = '0;
  bit [4:0] m_req;
  int       nx, ny;

  function automatic int npix(input int s);
    return (s + 1) * (s + 1);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_mode = M_INIT; m_cx = 0; m_cy = 0; m_pend = '0; m_rc = 0;
    end else begin
      m_req = {rf, mr, ml, md, mu};
      case (m_mode)
        M_INIT: begin
          m_ds = int'(size_in); m_dc = int'(colour_in); m_mode = M_DRAW; m_rc = 0;
          m_pend = m_pend | m_req;
        end
        M_IDLE: begin
          if (m_pend != 0) begin m_mode = paint ? M_MOVE : M_ERASE; m_rc = 0; end
          m_pend = m_pend | m_req;
        end
        M_ERASE, M_DRAW: begin
          if (m_rc == npix(m_ds) + 1) begin
            m_mode = (m_mode == M_ERASE) ? M_MOVE : M_IDLE;
            m_rc = 0;
          end else m_rc++;
          m_pend = m_pend | m_req;
        end
        default: begin // move
          nx = m_cy; ny = m_cy;
          nx = m_cx;
          if (m_pend[3] && !m_pend[2]) nx = nx + ST;
          if (m_pend[2] && !m_pend[3]) nx = (nx < ST) ? 0 : nx - ST;
          if (m_pend[1] && !m_pend[0]) ny = ny + ST;
          if (m_pend[0] && !m_pend[1]) ny = (ny < ST) ? 0 : ny - ST;
          if (nx > W - 1 - int'(size_in)) nx = W - 1 - int'(size_in);
          if (ny > H - 1 - int'(size_in)) ny = H - 1 - int'(size_in);
          m_cx = nx; m_cy = ny;
          m_ds = int'(size_in); m_dc = int'(colour_in);
          m_mode = M_DRAW; m_rc = 0;
          m_pend = m_req;
        end
      endcase
    end
  end

  // Plot log of what the DUT actually produced, for the directed checks.
  int  log_x[$], log_y[$], log_c[$];
  bit  run, eplot;
  int  k, s;

  always @(negedge clk) begin
    run   = (m_mode == M_ERASE) || (m_mode == M_DRAW);
    eplot = run && (m_rc >= 1) && (m_rc <= npix(m_ds));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    chk("sq_start", 32'(sq.sq_start), 32'(run));
    chk("plot", 32'(sq.plot), 32'(eplot));
    chk("cur_x", 32'(cur_x), 32'(m_cx));
    chk("cur_y", 32'(cur_y), 32'(m_cy));
    if (run) begin
      chk("sq_x", 32'(sq.sq_x), 32'(m_cx));
      chk("sq_y", 32'(sq.sq_y), 32'(m_cy));
      chk("sq_sx", 32'(sq.sq_sx), 32'(m_ds));
      chk("sq_sy", 32'(sq.sq_sy), 32'(m_ds));
    end
    if (eplot) begin
      k = m_rc - 1; s = m_ds;
      chk("colour_out", 32'(sq.colour_out), 32'((m_mode == M_ERASE) ? BG : m_dc));
      chk("pix_x", 32'(int'(sq.sq_x) + int'(d_xo)), 32'(m_cx + s - k / (s + 1)));
      chk("pix_y", 32'(int'(sq.sq_y) + int'(d_yo)), 32'(m_cy + s - k % (s + 1)));
    end
    if (sq.plot === 1'b1) begin
      log_x.push_back(int'(sq.sq_x) + int'(d_xo));
      log_y.push_back(int'(sq.sq_y) + int'(d_yo));
      log_c.push_back(int'(sq.colour_out));
    end
  end

  task automatic clear_log();
    log_x.delete(); log_y.delete(); log_c.delete();
  endtask

  task automatic chk_pix(input string nm, input int idx, input int x, input int y, input int c);
    if (idx < log_x.size()) begin
      chk({nm, "_x"}, 32'(log_x[idx]), 32'(x));
      chk({nm, "_y"}, 32'(log_y[idx]), 32'(y));
      chk({nm, "_c"}, 32'(log_c[idx]), 32'(c));
    end else begin
      chk({nm, "_missing"}, 32'(log_x.size()), 32'(idx + 1));
    end
  endtask

  task automatic pulse(input bit u, input bit d, input bit l, input bit r, input bit f);
    @(posedge clk); #1;
    mu = u; md = d; ml = l; mr = r; rf = f;
    @(posedge clk); #1;
    mu = 0; md = 0; ml = 0; mr = 0; rf = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    repeat (2) @(posedge clk);
    while (n < 3000) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({nm, "_idle_in_time"}, 32'(n < 3000), 32'd1);
  endtask

  task automatic wait_model(input int mode, input string nm);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (m_mode == mode && sq.plot === 1'b1) break;
      n++;
    end
    chk({nm, "_reached"}, 32'(n < 3000), 32'd1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int rst_cnt;

  initial begin
    // 1: power-up draw at (0,0), size 1, colour 100
    clear_log();
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    wait_idle("t1");
    chk("t1_count", 32'(log_x.size()), 32'd4);
    chk_pix("t1_p0", 0, 1, 1, 4);
    chk_pix("t1_p1", 1, 1, 0, 4);
    chk_pix("t1_p2", 2, 0, 1, 4);
    chk_pix("t1_p3", 3, 0, 0, 4);
    chk("t1_busy", 32'(busy), 32'd0);

    // 2: erase then draw one step right
    clear_log();
    pulse(0, 0, 0, 1, 0);
    wait_idle("t2");
    chk("t2_count", 32'(log_x.size()), 32'd8);
    chk_pix("t2_erase_first", 0, 1, 1, 0);
    chk_pix("t2_erase_last", 3, 0, 0, 0);
    chk_pix("t2_draw_first", 4, 2, 1, 4);
    chk_pix("t2_draw_last", 7, 1, 0, 4);
    chk("t2_cur_x", 32'(cur_x), 32'd1);

    // 3: trail mode, no erase
    paint = 1;
    clear_log();
    pulse(0, 1, 0, 0, 0);
    wait_idle("t3");
    chk("t3_count", 32'(log_x.size()), 32'd4);
    chk_pix("t3_first", 0, 2, 2, 4);
    chk("t3_cur_y", 32'(cur_y), 32'd1);

    // 4: saturate at origin, still redraw
    pulse(1, 0, 1, 0, 0);
    wait_idle("t4a");
    clear_log();
    pulse(1, 0, 1, 0, 0);
    wait_idle("t4b");
    chk("t4_cur_x", 32'(cur_x), 32'd0);
    chk("t4_cur_y", 32'(cur_y), 32'd0);
    chk("t4_count", 32'(log_x.size()), 32'd4);
    chk_pix("t4_first", 0, 1, 1, 4);

    // 5: right-edge clamp, then clamp on refresh after growing
    size_in = 4'd3;
    for (int i = 0; i < 200; i++) begin
      pulse(0, 0, 0, 1, 0);
      wait_idle("t5_walk");
      if (cur_x == 8'd156) break;
    end
    pulse(0, 0, 0, 1, 0);
    wait_idle("t5_edge");
    chk("t5_clamp", 32'(cur_x), 32'd156);
    size_in = 4'd5;
    clear_log();
    pulse(0, 0, 0, 0, 1);
    wait_idle("t5_grow");
    chk("t5_grow_x", 32'(cur_x), 32'd154);
    chk("t5_count", 32'(log_x.size()), 32'd36);
    chk_pix("t5_first", 0, 159, 5, 4);

    // 6: request during DRAW, reset in the follow-on ERASE
    size_in = 4'd1;
    paint = 0;
    pulse(0, 0, 0, 0, 1);
    wait_model(M_DRAW, "t6_draw");
    pulse(0, 0, 0, 1, 0);
    wait_model(M_ERASE, "t6_erase");
    @(posedge clk); #1 resetn = 0;
    #1;
    chk("t6_start_drop", 32'(sq.sq_start), 32'd0);
    chk("t6_plot_drop", 32'(sq.plot), 32'd0);
    repeat (3) @(posedge clk);
    clear_log();
    #1 resetn = 1;
    wait_idle("t6_init");
    chk("t6_cur_x", 32'(cur_x), 32'd0);
    chk("t6_cur_y", 32'(cur_y), 32'd0);
    chk("t6_count", 32'(log_x.size()), 32'd4);
    chk_pix("t6_first", 0, 1, 1, 4);

    // Randomized phase, checked cycle by cycle by the model
    rst_cnt = 0;
    for (int cyc = 0; cyc < 15000; cyc++) begin
      @(posedge clk); #1;
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) resetn = 1;
      end else if ($urandom_range(0, 2999) == 0) begin
        resetn = 0;
        rst_cnt = $urandom_range(1, 3);
      end
      mu = ($urandom_range(0, 15) == 0);
      md = ($urandom_range(0, 15) == 0);
      ml = ($urandom_range(0, 15) == 0);
      mr = ($urandom_range(0, 12) == 0);
      rf = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 63) == 0) paint = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        size_in = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) colour_in = 3'($urandom_range(0, 7));
    end
    @(posedge clk); #1;
    mu = 0; md = 0; ml = 0; mr = 0; rf = 0; resetn = 1;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/paint_cursor_ctrl.md
Name: paint_cursor_ctrl

Overview:
- Upstream controller for the square-drawing stage. Holds the brush cursor position and turns move/refresh requests into draw runs on the square drawer.
- When the trail is off, it first erases the old cursor square in background colour, then draws the new one.
- It generates the VGA plot strobe and colour alongside the square drawer's pixel coordinates.

Parameters:
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
STEP, 1, pixels moved per accepted move request
BG_COLOUR, 3'b000, colour used for erase runs

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
move_up  in  1  one-cycle move request, y-STEP
move_down  in  1  one-cycle move request, y+STEP
move_left  in  1  one-cycle move request, x-STEP
move_right  in  1  one-cycle move request, x+STEP
refresh  in  1  one-cycle request to redraw with no movement
paint  in  1  level; 1 = leave trail (skip erase)
colour_in  in  3  brush colour
size_in  in  4  brush size; square spans size_in+1 pixels per side
sq_done  in  1  Done from square drawer
sq_start  out  1  start to square drawer
sq_x, sq_y  out  8 each  square origin
sq_sx, sq_sy  out  4 each  square size (both equal)
plot  out  1  VGA write enable
colour_out  out  3  VGA colour
cur_x, cur_y  out  8 each  current cursor origin
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, resetn=0):
  - state=INIT; cur_x=cur_y=0; pending=0; sq_start=0; sq_start_q=0; plot=0.
  - drawn_size and drawn_colour are loaded from size_in and colour_in at the INIT->DRAW transition.
- States: INIT, IDLE, ERASE, MOVE, DRAW.
- INIT: latches size_in and colour_in into drawn_size and drawn_colour, then goes to DRAW next cycle.
- Pending requests:
  - A 5-bit mask {refresh,R,L,D,U} is ORed with the request inputs every cycle, in any state.
  - MOVE clears the bits it consumed in that cycle. A request arriving in the same MOVE cycle stays set.
- IDLE: if pending≠0, go to MOVE when paint=1, else go to ERASE.
- ERASE:
  - sq_start=1; sq_x/sq_y=cur; sq_sx=sq_sy=drawn_size; colour_out=BG_COLOUR.
  - On done_ack, sq_start=0 and go to MOVE.
- MOVE (exactly 1 cycle, sq_start=0):
  - Applies pending: U and D together cancel; L and R together cancel; diagonals allowed.
  - Latches new size and colour into drawn_size and drawn_colour.
- Move arithmetic:
  - Computed in 9 bits.
  - Decrements saturate at 0 (no wrap).
  - x is clamped to ≤ SCREEN_W-1-size_in and y to ≤ SCREEN_H-1-size_in. This clamp also applies on refresh and when the size grows.
- DRAW:
  - sq_start=1; origin=cur; size=drawn_size; colour_out=drawn_colour.
  - On done_ack, sq_start=0 and go to IDLE.
- Square drawer handshake:
  - The drawer's Done stays high after a run until start is re-asserted. On a run's first cycle with start high, Done is stale.
  - done_ack = sq_start & sq_start_q & sq_done, where sq_start_q is sq_start delayed one cycle.
  - plot = sq_start & sq_start_q & ~sq_done. The first cycle of each run is a reload cycle and produces no plot.
- Run length: (drawn_size+1)² plot cycles per run. sq_start is held high (1 + pixels + 1) cycles.
- Simultaneous events:
  - A request during ERASE or DRAW is only latched. The run is never aborted.
  - A paint change mid-run takes effect at the next IDLE decision.
- Reset mid-run: sq_start drops immediately. The drawer has no reset; its stale Done is masked by sq_start_q=0.

Test Plan:
1. Reset, size_in=1, colour_in=3'b100 -> INIT->DRAW; exactly 4 plot pulses at (1,1),(1,0),(0,1),(0,0) in drawer order, colour 100; then IDLE, busy=0.
2. paint=0, move_right pulse at cur=(0,0), size 1 -> 4 erase plots colour 000 at x 0..1, then 4 draw plots at x 1..2; cur_x=1.
3. paint=1, move_down -> no erase run; only 4 draw plots at the new y; cur_y=1.
4. cur=(0,0), move_left+move_up -> position stays (0,0), no wrap to 255; redraw still occurs.
5. size_in=3, cur_x=156, move_right -> cur_x clamps to 156; refresh after changing to size_in=5 -> cur_x=154.
6. Pulse move_right during DRAW, then assert resetn=0 mid-ERASE of the follow-on run -> sq_start=0 and plot=0 immediately; after release, INIT redraw at (0,0) with no spurious done_ack.
